// File: rtl/psc_packet_rx.sv
// psc_packet_rx: PSC link receive framer (SOP, status, addr x2, data x4, CRC, EOP).
// Optional CRC-8 check of bytes 1..7 against byte 8 when PSC_RX_CRC_CHECK_EN is defined.
module psc_packet_rx #(
  parameter logic [7:0]  SOP_BYTE     = 8'h3C,
  parameter logic [7:0]  EOP_BYTE     = 8'hBC,
  parameter logic [15:0] TRIGGER_ADDR = 16'h7000,
  parameter logic [15:0] IDLE_ADDR    = 16'h4000,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_is_k_i,
  output logic        pkt_valid_o,
  output logic [7:0]  pkt_status_o,
  output logic [15:0] pkt_addr_o,
  output logic [31:0] pkt_data_o,
  output logic        trigger_out_o,
  output logic        idle_seen_o,
  output logic        frame_err_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_BODY = 2'd1,
    S_EOP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [55:0]   body_q, body_d;
  logic          commit, err, crc_ok, sop;

  logic        pkt_valid_q, trig_q, idle_q, ferr_q;
  logic [7:0]  status_q;
  logic [15:0] addr_q, errcnt_q;
  logic [31:0] data_q;

  assign sop = rx_valid_i && rx_is_k_i && (rx_byte_i == SOP_BYTE);

`ifdef PSC_RX_CRC_CHECK_EN
  logic [7:0] crc_q, crc_rx_q;

  // CRC-8, poly 0x07, MSB-first
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = (c[7] ^ b[i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      crc_q    <= 8'h00;
      crc_rx_q <= 8'h00;
    end else if (sop) begin
      crc_q <= 8'h00;
    end else if (state_q == S_BODY && rx_valid_i && !rx_is_k_i) begin
      if (idx_q == 4'd8) crc_rx_q <= rx_byte_i;
      else               crc_q    <= crc8_step(crc_q, rx_byte_i);
    end
  end

  assign crc_ok = (crc_q == crc_rx_q);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    body_d  = body_q;
    commit  = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_HUNT: begin
        cnt_d = '0;
        if (sop) begin
          state_d = S_BODY;
          idx_d   = 4'd1;
        end
      end
      S_BODY, S_EOP: begin
        if (!rx_valid_i) begin
          if (cnt_q == TO_LAST) begin
            err     = 1'b1;
            state_d = S_HUNT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
          if (sop) begin
            // a fresh SOP aborts the current packet but starts a new one
            err     = 1'b1;
            state_d = S_BODY;
            idx_d   = 4'd1;
          end else if (state_q == S_BODY) begin
            if (rx_is_k_i) begin
              err     = 1'b1;
              state_d = S_HUNT;
            end else begin
              if (idx_q != 4'd8) body_d = {body_q[47:0], rx_byte_i};
              if (idx_q == 4'd8) state_d = S_EOP;
              else               idx_d   = idx_q + 4'd1;
            end
          end else begin
            state_d = S_HUNT;
            if (rx_is_k_i && rx_byte_i == EOP_BYTE && crc_ok) commit = 1'b1;
            else                                               err    = 1'b1;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_HUNT;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      body_q      <= '0;
      pkt_valid_q <= 1'b0;
      trig_q      <= 1'b0;
      idle_q      <= 1'b0;
      ferr_q      <= 1'b0;
      status_q    <= 8'h00;
      addr_q      <= 16'h0000;
      data_q      <= 32'h0;
      errcnt_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      body_q      <= body_d;
      pkt_valid_q <= commit;
      trig_q      <= commit && (body_q[47:32] == TRIGGER_ADDR);
      idle_q      <= commit && (body_q[47:32] == IDLE_ADDR);
      ferr_q      <= err;
      if (commit) begin
        status_q <= body_q[55:48];
        addr_q   <= body_q[47:32];
        data_q   <= body_q[31:0];
      end
      if (err && errcnt_q != 16'hFFFF) errcnt_q <= errcnt_q + 16'd1;
    end
  end

  assign pkt_valid_o   = pkt_valid_q;
  assign pkt_status_o  = status_q;
  assign pkt_addr_o    = addr_q;
  assign pkt_data_o    = data_q;
  assign trigger_out_o = trig_q;
  assign idle_seen_o   = idle_q;
  assign frame_err_o   = ferr_q;
  assign err_count_o   = errcnt_q;

endmodule
